// File: rtl/tiny_pkg.sv
// Shared definitions for the fetch front end: fetch FSM encoding,
// the default halt opcode and the pair-queue depth.
package tiny_pkg;

  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    F_ARG = 2'd1,
    HALT  = 2'd2
  } fstate_e;

  localparam logic [7:0] HALT_OP_DEF = 8'hFF;
  localparam int         QDEPTH      = 2;

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-read, instruction-output and redirect signals of the fetch queue.
// master is the fetch_queue side, slave is the memory/control-unit side.
interface fetch_queue_if #(
  parameter int WIDTH = 8
);
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_inst;
  logic [WIDTH-1:0] out_operand;
  logic [WIDTH-1:0] out_pc;
  logic             redir_valid;
  logic [WIDTH-1:0] redir_pc;
  logic             halted;

  modport master (
    output mem_req, mem_addr, out_valid, out_inst, out_operand, out_pc, halted,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready, redir_valid, redir_pc
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_inst, out_operand, out_pc, halted,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/pair_fifo.sv
// Two-entry FIFO of packed instruction pairs; a push into a full queue is
// accepted when a pop happens in the same cycle.
module pair_fifo
  import tiny_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [DW-1:0] mem_q [QDEPTH];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          do_push, do_pop;

  assign empty_o    = (count_q == 2'd0);
  assign full_o     = (count_q == 2'(QDEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= !wr_ptr_q;
      if (do_pop)  rd_ptr_q <= !rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: reads opcode/operand word pairs from memory
// and buffers up to two complete pairs for the control unit.
module fetch_queue
  import tiny_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [7:0]       HALT_OP  = HALT_OP_DEF
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int PAIR_W = 8 + 2 * WIDTH;

  fstate_e          state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, op_pc_q, op_pc_d;
  logic [7:0]       op_q, op_d;
  logic             pend_q, pend_d, pend_op_q, pend_op_d;
  logic             live_q;

  logic             grant, op_rsp, arg_rsp, halt_hit;
  logic [1:0]       occ, inflight;
  logic [WIDTH-1:0] addr;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PAIR_W-1:0] fifo_rdata;

  // pend_q tags the single request whose response lands next cycle; clearing
  // it is how redirect, reset and halt discard stale read data.
  assign grant    = bus.mem_req && bus.mem_gnt;
  assign op_rsp   = pend_q && pend_op_q && bus.mem_rvalid;
  assign arg_rsp  = pend_q && !pend_op_q && bus.mem_rvalid;
  assign halt_hit = op_rsp && (bus.mem_rdata[7:0] == HALT_OP);
  assign occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign inflight = 2'(state_q == F_ARG) + 2'(pend_q && !pend_op_q);

  always_comb begin
    bus.mem_req = 1'b0;
    addr        = pc_q;
    case (state_q)
      F_OP:    bus.mem_req = live_q && ((3'(occ) + 3'(inflight)) < 3'd2);
      F_ARG: begin
        bus.mem_req = 1'b1;
        addr        = pc_q + WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign bus.mem_addr = bus.mem_req ? addr : '0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = grant;
    pend_op_d = grant ? (state_q == F_OP) : pend_op_q;
    op_d      = op_q;
    op_pc_d   = op_pc_q;
    case (state_q)
      F_OP:  if (grant) state_d = F_ARG;
      F_ARG: begin
        if (halt_hit) begin
          state_d = HALT;
          pend_d  = 1'b0;
        end else if (grant) begin
          state_d = F_OP;
          pc_d    = pc_q + WIDTH'(2);
        end
      end
      default: ;
    endcase
    if (op_rsp) begin
      op_d    = bus.mem_rdata[7:0];
      op_pc_d = pc_q;
    end
    if (bus.redir_valid) begin
      state_d = F_OP;
      pc_d    = bus.redir_pc;
      pend_d  = 1'b0;
    end
  end

  // live_q keeps mem_req low for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= F_OP;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_op_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_op_q <= pend_op_d;
      live_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    op_pc_q <= op_pc_d;
  end

  assign fifo_push = arg_rsp && !bus.redir_valid;
  assign fifo_pop  = bus.out_valid && bus.out_ready;

  pair_fifo #(.DW(PAIR_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redir_valid),
    .push_i      (fifo_push),
    .push_data_i ({op_q, bus.mem_rdata, op_pc_q}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign {bus.out_inst, bus.out_operand, bus.out_pc} = bus.out_valid ? fifo_rdata : '0;
  assign bus.halted = (state_q == HALT);
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model, program-order reference stream and a
// scoreboard monitor, with directed scenarios followed by a randomized run.
module tb_fetch_queue;
  localparam int         W      = 8;
  localparam logic [7:0] RST_PC = 8'h00;

  typedef struct packed {
    logic [7:0] inst;
    logic [7:0] opd;
    logic [7:0] pc;
  } pair_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(W)) bus ();

  fetch_queue #(.WIDTH(W), .RESET_PC(RST_PC), .HALT_OP(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  pair_t      expq [$];
  logic [7:0] seen [$];
  logic [7:0] gen_pc;
  bit         gen_halt;
  int         total = 0;
  int         bad   = 0;
  bit         found;
  int         g, v;
  logic [15:0] pcs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference stream: walk memory two bytes at a time from the start pc
  // until an opcode equal to the halt value is met.
  task automatic restart(input logic [7:0] pc);
    expq.delete();
    seen.delete();
    gen_pc   = pc;
    gen_halt = 1'b0;
  endtask

  task automatic topup();
    while (!gen_halt && expq.size() < 8) begin
      if (mem[gen_pc] == 8'hFF) gen_halt = 1'b1;
      else begin
        expq.push_back({mem[gen_pc], mem[gen_pc + 8'd1], gen_pc});
        gen_pc = gen_pc + 8'd2;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic redirect(input logic [7:0] t);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = t;
    @(posedge clk);
    #1;
    bus.redir_valid = 1'b0;
    restart(t);
    topup();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mem_req"},   {31'h0, bus.mem_req},   32'd0);
    check({tag, "_out_valid"}, {31'h0, bus.out_valid}, 32'd0);
    check({tag, "_halted"},    {31'h0, bus.halted},    32'd0);
    check({tag, "_out_inst"},  {24'h0, bus.out_inst},  32'd0);
    check({tag, "_out_opd"},   {24'h0, bus.out_operand}, 32'd0);
    check({tag, "_out_pc"},    {24'h0, bus.out_pc},    32'd0);
  endtask

  // Memory answers every granted read exactly one cycle later.
  always @(posedge clk) begin
    bus.mem_rvalid <= bus.mem_req && bus.mem_gnt;
    bus.mem_rdata  <= mem[bus.mem_addr];
  end

  pair_t      got, want, held;
  logic       hold_chk  = 1'b0;
  logic       stall_chk = 1'b0;
  logic [7:0] stall_addr;

  always @(negedge clk) begin
    got = {bus.out_inst, bus.out_operand, bus.out_pc};
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        seen.push_back(bus.out_pc);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pair_extra: got %h want none", got);
        end else begin
          want = expq.pop_front();
          check("pair", {8'h0, got}, {8'h0, want});
        end
      end
      if (hold_chk)
        check("hold_stable", {7'h0, bus.out_valid, got}, {7'h0, 1'b1, held});
      if (stall_chk && !bus.halted)
        check("gnt_stall", {23'h0, bus.mem_req, bus.mem_addr}, {23'h0, 1'b1, stall_addr});
      if (bus.halted)
        check("halt_noreq", {31'h0, bus.mem_req}, 32'd0);
    end
    hold_chk   = !reset && bus.out_valid && !bus.out_ready && !bus.redir_valid;
    held       = got;
    stall_chk  = !reset && bus.mem_req && !bus.mem_gnt && !bus.redir_valid;
    stall_addr = bus.mem_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.mem_gnt     = 1'b1;
    bus.out_ready   = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
    mem[8'h00] = 8'h41; mem[8'h01] = 8'h0D; mem[8'h02] = 8'h48; mem[8'h03] = 8'h0B;
    mem[8'h63] = 8'h12; mem[8'h64] = 8'h34;
    mem[8'hC8] = 8'hFF;
    mem[8'hFE] = 8'h05; mem[8'hFF] = 8'h77;

    // Reset state and first-pair latency
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("rst");
    restart(RST_PC);
    topup();
    g = -1;
    v = -1;
    for (int i = 0; i < 12; i++) begin
      if (g < 0 && bus.mem_req && bus.mem_gnt) g = i;
      if (v < 0 && bus.out_valid) v = i;
      tick();
    end
    check("first_latency", 32'(v - g), 32'd3);
    pcs = (seen.size() >= 2) ? {seen[0], seen[1]} : 16'hDEAD;
    check("first_pcs", {16'h0, pcs}, 32'h0002);

    // Back-pressure fills the queue with exactly two pairs
    bus.out_ready = 1'b0;
    repeat (10) tick();
    check("bp_mem_req", {31'h0, bus.mem_req}, 32'd0);
    check("bp_valid", {31'h0, bus.out_valid}, 32'd1);
    seen.delete();
    bus.mem_gnt   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("bp_drain_count", 32'(seen.size()), 32'd2);
    bus.mem_gnt = 1'b1;

    // Randomized grants, back-pressure and redirects
    for (int i = 0; i < 400; i++) begin
      bus.mem_gnt   = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 39) == 0) redirect(8'($urandom));
      else tick();
    end

    // Redirect while an operand read is outstanding
    bus.mem_gnt   = 1'b1;
    bus.out_ready = 1'b1;
    redirect(8'h20);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_req && bus.mem_gnt && bus.mem_addr == 8'h21) found = 1'b1;
      else tick();
    end
    check("operand_grant_seen", {31'h0, found}, 32'd1);
    redirect(8'h63);
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    check("redir_valid", {31'h0, bus.out_valid}, 32'd1);
    check("redir_pc", {24'h0, bus.out_pc}, 32'h63);

    // Address wrap at the top of the space
    redirect(8'hFE);
    repeat (12) tick();
    pcs = (seen.size() >= 2) ? {seen[0], seen[1]} : 16'hDEAD;
    check("wrap_pcs", {16'h0, pcs}, 32'hFE00);

    // Halt opcode with one pair queued ahead of it
    bus.out_ready = 1'b0;
    redirect(8'hC6);
    for (int i = 0; i < 20 && !bus.halted; i++) tick();
    check("halt_set", {31'h0, bus.halted}, 32'd1);
    check("halt_keeps_pair", {23'h0, bus.out_valid, bus.out_pc}, {23'h0, 1'b1, 8'hC6});
    repeat (5) tick();
    check("halt_mem_req", {31'h0, bus.mem_req}, 32'd0);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("halt_drained_valid", {31'h0, bus.out_valid}, 32'd0);
    check("halt_drained_count", 32'(seen.size()), 32'd1);
    check("halt_stays", {31'h0, bus.halted}, 32'd1);
    redirect(8'h10);
    check("halt_cleared", {31'h0, bus.halted}, 32'd0);
    repeat (10) tick();
    check("resume_pc", {24'h0, (seen.size() > 0) ? seen[0] : 8'hEE}, 32'h10);

    // Reset with reads outstanding, coincident with a redirect
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.mem_req && bus.mem_gnt) found = 1'b1;
      else tick();
    end
    check("pre_reset_grant", {31'h0, found}, 32'd1);
    reset           = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 8'h40;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.redir_valid = 1'b0;
    check_idle("rst2");
    restart(RST_PC);
    topup();
    repeat (15) tick();
    check("rst2_first_pc", {24'h0, (seen.size() > 0) ? seen[0] : 8'hEE}, 32'h00);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default 8: data/address width of the accumulator datapath.
REQ-002 Parameter RESET_PC, default 0: address of the first instruction byte after reset.
REQ-003 Parameter HALT_OP, default 8'hFF: opcode that stops fetching.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_req  output  1  read request to memory this cycle.
REQ-007 mem_addr  output  WIDTH  read address, valid when mem_req=1.
REQ-008 mem_gnt  input  1  memory accepts the request this cycle.
REQ-009 mem_rvalid  input  1  read data valid; always exactly one cycle after a granted request.
REQ-010 mem_rdata  input  WIDTH  read data.
REQ-011 out_valid  output  1  an instruction pair is presented to the control unit.
REQ-012 out_ready  input  1  control unit consumes the pair when out_valid=1.
REQ-013 out_inst  output  8  opcode byte (type in [7:6], opcode in [5:0]).
REQ-014 out_operand  output  WIDTH  operand/address word following the opcode.
REQ-015 out_pc  output  WIDTH  address of out_inst.
REQ-016 redir_valid  input  1  taken jump; flush and refetch.
REQ-017 redir_pc  input  WIDTH  jump target (address of the next opcode).
REQ-018 halted  output  1  HALT_OP fetched; no further requests.

Function
REQ-019 The block SHALL fetch instructions as two consecutive words: opcode at pc, operand at pc+1, with pc advancing by 2 per pair, modulo 2**WIDTH.
REQ-020 The FSM SHALL have the states F_OP (fetch opcode), F_ARG (fetch operand) and HALT; it SHALL move F_OP->F_ARG on the granted opcode request and F_ARG->F_OP on the granted operand request.
REQ-021 An opcode word equal to HALT_OP SHALL enter HALT on its response, cancel any in-flight operand request, enqueue no pair, and assert halted.
REQ-022 The queue SHALL hold 2 complete pairs; mem_req SHALL assert in F_OP only when occupancy plus pairs in flight is below 2.
REQ-023 A pair SHALL be enqueued on the cycle its operand response arrives; that pair SHALL be visible on out_valid no earlier than the following cycle.
REQ-024 Minimum latency SHALL be 3 cycles from the opcode request grant to out_valid, given mem_gnt=1 throughout.
REQ-025 Enqueue and dequeue in the same cycle with a full queue SHALL both succeed and leave occupancy unchanged.
REQ-026 Outputs out_inst/out_operand/out_pc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 On redir_valid, on the next edge the block SHALL empty the queue, discard any response to requests issued before the redirect, set pc=redir_pc, clear HALT, and enter F_OP.
REQ-028 A handshake (out_valid&out_ready) coincident with redir_valid SHALL count as consumed; the redirect still flushes everything else.
REQ-029 In HALT, mem_req SHALL be 0 and out_valid SHALL drain the remaining queued pairs normally.
REQ-030 With mem_gnt=0 the block SHALL hold mem_req, mem_addr and state unchanged.

Reset
REQ-031 On reset: pc=RESET_PC, state F_OP, queue empty, in-flight tags cleared, mem_req=0, out_valid=0, halted=0, out_inst/out_operand/out_pc=0.
REQ-032 Reset asserted mid-fetch SHALL cause any response arriving the cycle after reset deassertion to be discarded.
REQ-033 Reset SHALL take priority over redir_valid.

Structure
REQ-034 The FSM state encoding, HALT_OP, and the queue depth constant SHALL live in the shared package tiny_pkg.
REQ-035 The 2-entry pair storage SHALL be a sub-module pair_fifo (depth 2, push/pop/full/empty, simultaneous push-pop on full allowed).

Verification
REQ-036 Program 41,0D,48,0B at RESET_PC=0, mem_gnt=1, out_ready=1 -> pairs (41,0D,pc 0) then (48,0B,pc 2); first out_valid 3 cycles after the first grant.
REQ-037 out_ready=0 for 10 cycles -> exactly 2 pairs queued, mem_req=0 after the second pair, outputs stable; release -> pairs in program order.
REQ-038 redir_valid with redir_pc=0x63 while an operand read is in flight -> stale response dropped; next out_pc=0x63.
REQ-039 Opcode FF at address 0xC8 -> halted=1, no mem_req afterwards, preceding queued pairs still delivered; redirect to 0x10 -> fetching resumes.
REQ-040 WIDTH=8, pc=0xFE -> operand fetched from 0xFF, next opcode from 0x00.
REQ-041 reset asserted while mem_rvalid is pending -> all outputs zero next cycle; first pair after release comes from RESET_PC.
